// File: rtl/theta_update.sv
// One SGD step on eight signed 8-bit weights, one weight per cycle, valid/ready on both sides.
// Define THETA_SAT_EN to saturate updated weights to [-128,127]; otherwise results wrap to 8 bits.
module theta_update #(
    parameter int unsigned ALPHA_SHIFT = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] x,
    input  logic [63:0] teta,
    input  logic [7:0]  h,
    input  logic        y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] teta_out,
    output logic [15:0] upd_cnt
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e      state_q, state_d;
    logic [2:0]  j_q, j_d;
    logic [63:0] x_q, x_d;
    logic [63:0] teta_out_q, teta_out_d;
    logic [7:0]  h_q, h_d;
    logic        lbl_q, lbl_d;
    logic [15:0] cnt_q, cnt_d;

    logic [7:0]         x_j;
    logic signed [7:0]  teta_j;
    logic signed [8:0]  err;
    logic signed [17:0] grad;
    logic signed [17:0] step;
    logic signed [18:0] new_w;
    logic [7:0]         new_byte;

    // The weight being updated is read back from teta_out, which still holds the captured byte.
    always_comb begin
        x_j    = x_q[{j_q, 3'b000} +: 8];
        teta_j = $signed(teta_out_q[{j_q, 3'b000} +: 8]);
        err    = $signed({1'b0, h_q}) - $signed({1'b0, {8{lbl_q}}});
        grad   = 18'(err) * 18'($signed({1'b0, x_j}));
        step   = grad >>> ALPHA_SHIFT;
        new_w  = 19'(teta_j) - 19'(step);
`ifdef THETA_SAT_EN
        if (new_w > 19'sd127) begin
            new_byte = 8'h7F;
        end else if (new_w < -19'sd128) begin
            new_byte = 8'h80;
        end else begin
            new_byte = new_w[7:0];
        end
`else
        new_byte = new_w[7:0];
`endif
    end

    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        x_d        = x_q;
        teta_out_d = teta_out_q;
        h_d        = h_q;
        lbl_d      = lbl_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d        = x;
                    teta_out_d = teta;
                    h_d        = h;
                    lbl_d      = y;
                    j_d        = 3'd0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                teta_out_d[{j_q, 3'b000} +: 8] = new_byte;
                j_d = j_q + 3'd1;
                if (j_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            j_q        <= '0;
            x_q        <= '0;
            teta_out_q <= '0;
            h_q        <= '0;
            lbl_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            x_q        <= x_d;
            teta_out_q <= teta_out_d;
            h_q        <= h_d;
            lbl_q      <= lbl_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign teta_out  = teta_out_q;
    assign upd_cnt   = cnt_q;

endmodule

// File: tb/tb_theta_update.sv
// Scoreboard bench for theta_update: driver pushes expected vectors, a negedge monitor pops on handshake.
module tb_theta_update;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] x = '0;
    logic [63:0] teta = '0;
    logic [7:0]  h = '0;
    logic        y = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] teta_out;
    logic [15:0] upd_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_cnt = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    theta_update #(.ALPHA_SHIFT(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .teta(teta), .h(h), .y(y),
        .out_valid(out_valid), .out_ready(out_ready),
        .teta_out(teta_out), .upd_cnt(upd_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got %h expected none", teta_out);
            end else begin
                mon_exp = exp_q.pop_front();
                check("teta_out", teta_out, mon_exp);
                check("upd_cnt_pre", 64'(upd_cnt), 64'(exp_cnt));
                exp_cnt++;
            end
        end
    end

    task automatic send(input logic [63:0] xv, input logic [63:0] tv, input logic [7:0] hv,
                        input logic yv, input logic [63:0] ev, input int hold, input bit abort);
        int t;
        int lat;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            check("ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        x = xv; teta = tv; h = hv; y = yv; in_valid = 1'b1;
        exp_q.push_back(ev);
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = {$urandom, $urandom}; teta = {$urandom, $urandom}; h = 8'($urandom); y = ~yv;
        check("in_ready_busy", 64'(in_ready), 64'd0);
        if (abort) begin
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b0;
            #1;
            check("rst_in_ready", 64'(in_ready), 64'd1);
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_teta_out", teta_out, 64'd0);
            check("rst_upd_cnt", 64'(upd_cnt), 64'd0);
            void'(exp_q.pop_back());
            exp_cnt = 0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'd8);
        for (int i = 0; i < hold; i++) begin
            in_valid = ~i[0];
            x = {$urandom, $urandom}; teta = {$urandom, $urandom};
            check("bp_teta_out", teta_out, ev);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready_after", 64'(in_ready), 64'd1);
        check("out_valid_after", 64'(out_valid), 64'd0);
        check("upd_cnt", 64'(upd_cnt), 64'(exp_cnt));
    endtask

    localparam logic [63:0] X_MIX  = {8'h07, 8'hFF, 8'h80, 8'h40, 8'h10, 8'h02, 8'h01, 8'h00};
    localparam logic [63:0] T_MIX  = {8'h20, 8'hFB, 8'h05, 8'h80, 8'h7F, 8'hF0, 8'h10, 8'h00};
    localparam logic [63:0] T_ERR0 = 64'h0123_4567_89AB_CDEF;
`ifdef THETA_SAT_EN
    localparam logic [63:0] E_OVF  = {8{8'h7F}};
    localparam logic [63:0] E_NEG  = {8{8'h80}};
    localparam logic [63:0] E_MIX  = {8'h27, 8'h7F, 8'h7F, 8'hBF, 8'h7F, 8'hF2, 8'h11, 8'h00};
`else
    localparam logic [63:0] E_OVF  = {8{8'h78}};
    localparam logic [63:0] E_NEG  = {8{8'h88}};
    localparam logic [63:0] E_MIX  = {8'h27, 8'hF7, 8'h83, 8'hBF, 8'h8F, 8'hF2, 8'h11, 8'h00};
`endif

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_teta_out", teta_out, 64'd0);
        check("reset_upd_cnt", 64'(upd_cnt), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send({8{8'h40}}, '0, 8'h80, 1'b0, {8{8'h80}}, 5, 1'b0);
        send({8{8'h01}}, '0, 8'h00, 1'b1, {8{8'h04}}, 0, 1'b0);
        send({8{8'hFF}}, {8{8'h7F}}, 8'h00, 1'b1, E_OVF, 1, 1'b0);
        send({8{8'hFF}}, T_ERR0, 8'h00, 1'b0, T_ERR0, 0, 1'b0);
        send(X_MIX, T_MIX, 8'hC0, 1'b1, E_MIX, 2, 1'b0);
        send({8{8'hFF}}, {8{8'h80}}, 8'hFF, 1'b0, E_NEG, 0, 1'b0);
        send(X_MIX, T_MIX, 8'hC0, 1'b1, E_MIX, 0, 1'b1);
        send(X_MIX, T_MIX, 8'hC0, 1'b1, E_MIX, 0, 1'b0);
        send({8{8'h40}}, '0, 8'h80, 1'b0, {8{8'h80}}, 0, 1'b0);

        #20;
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/theta_update.md
# theta_update

- Training-side counterpart of the `phase1` inference path (`h = sigmoid(x·teta)`).
- Takes one sample (`x`), its label (`y`), the current weight vector (`teta`) and the prediction `h` produced by `phase1`.
- Performs one stochastic-gradient-descent step on the eight 8-bit weights, one weight per cycle, and returns the updated `teta`.
- Sits between the `phase1` output and the weight register file; valid/ready handshakes on both sides.

## Interface
Parameters:
- `ALPHA_SHIFT`, default 6: learning rate as a power of two; each step is scaled by 2^-ALPHA_SHIFT. Legal range 0..16.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `in_valid`  input  1  sample/weights/prediction presented.
- `in_ready`  output  1  block can accept a sample.
- `x`  input  64  eight unsigned 8-bit features; feature j = `x[8j+7:8j]`.
- `teta`  input  64  eight signed two's-complement 8-bit weights, same byte layout as `x`.
- `h`  input  8  prediction, unsigned Q0.8.
- `y`  input  1  label.
- `out_valid`  output  1  `teta_out` holds an updated weight vector.
- `out_ready`  input  1  consumer accepts `teta_out`.
- `teta_out`  output  64  updated weights, same layout as `teta`.
- `upd_cnt`  output  16  number of completed output handshakes.

## Operation
- FSM states and transitions:
  - IDLE: `in_ready`=1. On `in_valid && in_ready`, register `x`, `teta`, `h`, `y`, clear index `j`, go to CALC.
  - CALC: process byte `j`, increment `j`. After `j`=7, go to DONE.
  - DONE: `out_valid`=1. On `out_ready`, increment `upd_cnt` and go to IDLE.
- Arithmetic, per byte:
  - `y_q` = 8'hFF if `y`=1, else 8'h00.
  - `err` = signed 9-bit `h - y_q`, range -255..255.
  - `grad_j` = `err * x_j`, signed 18-bit.
  - `step_j` = `grad_j >>> ALPHA_SHIFT`: arithmetic shift, floor toward minus infinity.
  - `new_j` = `teta_j - step_j`, computed at 19 bits, then reduced to 8 bits per Configuration.
- `teta_out` is built in place: byte j is written at the end of CALC step j. Bytes not yet processed still hold the captured `teta`. The consumer samples only while `out_valid`=1.
- `in_valid` is ignored outside IDLE. Input buses need not be stable after acceptance.
- `upd_cnt` wraps 16'hFFFF -> 0.

## Timing
- Reset values: `in_ready`=1 (state IDLE), `out_valid`=0, `teta_out`=0, `upd_cnt`=0, `j`=0.
- Acceptance edge is T. CALC occupies edges T+1..T+8, processing bytes 0..7 in order. `out_valid` rises after edge T+8.
- Latency is 8 cycles from acceptance to `out_valid`.
- `in_ready` falls after edge T. It rises the cycle after the output handshake edge.
- Throughput is at most one sample per 10 cycles. Acceptance in the same cycle as the output handshake is not permitted.
- Backpressure: while DONE and `out_ready`=0, `teta_out` and `out_valid` hold indefinitely.
- `rst_n` asserted at any time, including mid-CALC: outputs return to reset values immediately, without waiting for a clock edge. The partially computed vector is discarded.
- `err`=0 (for example `h`=8'h00 with `y`=0) still takes 8 cycles; `teta_out` equals `teta`.

## Configuration
- `THETA_SAT_EN` defined: `new_j` saturates to [-128, 127]. Results above 127 become 8'h7F; results below -128 become 8'h80.
- `THETA_SAT_EN` undefined: `new_j` keeps its low 8 bits (two's-complement wrap).

## Test plan
- Reset: hold `rst_n`=0, then release. Expect `in_ready`=1, `out_valid`=0, `teta_out`=0, `upd_cnt`=0.
- Basic step: `ALPHA_SHIFT`=6, `h`=8'h80, `y`=0, `x`=all 8'h40, `teta`=0.
  - `err`=128, `grad`=8192, `step`=128.
  - Expect `teta_out`=all 8'h80, `out_valid` exactly 8 cycles after acceptance, `upd_cnt`=1 after handshake.
- Floor rounding: `h`=8'h00, `y`=1, `x`=all 8'h01, `teta`=0.
  - `grad`=-255, `step`=-4.
  - Expect `teta_out`=all 8'h04.
- Overflow: `teta`=all 8'h7F, `h`=8'h00, `y`=1, `x`=all 8'hFF.
  - `step`=-1017, `new`=1144.
  - Expect all 8'h7F with `THETA_SAT_EN`; all 8'h78 without.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE while pulsing `in_valid`.
  - Expect `teta_out` stable, `in_ready`=0, no new capture.
  - After the handshake, expect `in_ready`=1 on the next cycle.
- Reset mid-CALC: assert `rst_n`=0 at CALC byte 3.
  - Expect immediate reset values.
  - A subsequent sample produces correct results unaffected by the aborted one.
